// File: rtl/i2c_target_regs.sv
`default_nettype none
// ============================================================================
// Module   : i2c_target_regs
// Brief    : I2C target with an 8 x 8-bit register bank shared with a local
//            parallel port. Optional SCL/SDA majority filter under
//            I2C_TARGET_GLITCH_FILTER_EN.
// Revision : 1.0
// ============================================================================
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR = 7'h63
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  input  logic       loc_we,
  input  logic [2:0] loc_addr,
  input  logic [7:0] loc_wdata,
  output logic [7:0] loc_rdata,
  output logic       i2c_wr,
  output logic [2:0] i2c_wr_addr,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WRITE     = 4'd5,
    S_WRITE_ACK = 4'd6,
    S_READ      = 4'd7,
    S_MACK      = 4'd8
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_scl_sync, r_sda_sync;
  logic       w_scl, w_sda;
  logic       r_scl_d, r_sda_d;
  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [7:0] r_shreg, w_shreg_nxt;
  logic [2:0] r_ptr, w_ptr_nxt;
  logic       r_sda_oe, w_oe_nxt;
  logic       r_rw, w_rw_nxt;
  logic       r_busy, w_busy_nxt;
  logic       w_commit;
  logic [7:0] w_byte;
  logic [7:0] w_rd_cur, w_rd_nxt;
  logic       r_i2c_wr;
  logic [2:0] r_wr_addr;
  logic [7:0] r_regs [8];

  // Pads idle high, so the synchronizers reset high to avoid a false event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_i};
      r_sda_sync <= {r_sda_sync[0], sda_i};
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [1:0] r_scl_hist, r_sda_hist;
  logic       r_scl_flt, r_sda_flt;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_hist <= 2'b11;
      r_sda_hist <= 2'b11;
      r_scl_flt  <= 1'b1;
      r_sda_flt  <= 1'b1;
    end else begin
      r_scl_hist <= {r_scl_hist[0], r_scl_sync[1]};
      r_sda_hist <= {r_sda_hist[0], r_sda_sync[1]};
      r_scl_flt  <= maj3(r_scl_sync[1], r_scl_hist[0], r_scl_hist[1]);
      r_sda_flt  <= maj3(r_sda_sync[1], r_sda_hist[0], r_sda_hist[1]);
    end
  end

  assign w_scl = r_scl_flt;
  assign w_sda = r_sda_flt;
`else
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_rd_cur   = r_regs[r_ptr];
  assign w_rd_nxt   = r_regs[r_ptr + 3'd1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // In ACK states r_cnt==0 means the ACK drive has not started yet.
  // In READ, r_cnt==8 means the first bit still has to be put on the bus.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_ptr_nxt   = r_ptr;
    w_oe_nxt    = r_sda_oe;
    w_rw_nxt    = r_rw;
    w_busy_nxt  = r_busy;
    w_commit    = 1'b0;
    w_byte      = {r_shreg[6:0], w_sda};
    if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
      w_cnt_nxt   = 4'd0;
      w_oe_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_shreg_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt = 4'd0;
              if (w_byte[7:1] == DEV_ADDR) begin
                w_state_nxt = S_ADDR_ACK;
                w_rw_nxt    = w_byte[0];
                w_busy_nxt  = 1'b1;
              end else begin
                w_state_nxt = S_IDLE;
              end
            end
          end
        end
        S_ADDR_ACK, S_PTR_ACK, S_WRITE_ACK: begin
          if (w_scl_fall) begin
            if (r_cnt == 4'd0) begin
              w_oe_nxt  = 1'b1;
              w_cnt_nxt = 4'd1;
            end else begin
              w_oe_nxt  = 1'b0;
              w_cnt_nxt = 4'd0;
              if (r_state == S_ADDR_ACK && r_rw) begin
                w_state_nxt = S_READ;
                w_shreg_nxt = w_rd_cur;
                w_oe_nxt    = ~w_rd_cur[7];
              end else if (r_state == S_ADDR_ACK) begin
                w_state_nxt = S_PTR;
              end else begin
                w_state_nxt = S_WRITE;
              end
            end
          end
        end
        S_PTR: begin
          if (w_scl_rise) begin
            w_shreg_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt   = 4'd0;
              w_ptr_nxt   = w_byte[2:0];
              w_state_nxt = S_PTR_ACK;
            end
          end
        end
        S_WRITE: begin
          if (w_scl_rise) begin
            w_shreg_nxt = w_byte;
            w_cnt_nxt   = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt   = 4'd0;
              w_commit    = 1'b1;
              w_ptr_nxt   = r_ptr + 3'd1;
              w_state_nxt = S_WRITE_ACK;
            end
          end
        end
        S_READ: begin
          if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_oe_nxt  = ~r_shreg[7];
              w_cnt_nxt = 4'd0;
            end else if (r_cnt == 4'd7) begin
              w_oe_nxt    = 1'b0;
              w_cnt_nxt   = 4'd0;
              w_state_nxt = S_MACK;
            end else begin
              w_shreg_nxt = {r_shreg[6:0], 1'b0};
              w_oe_nxt    = ~r_shreg[6];
              w_cnt_nxt   = r_cnt + 4'd1;
            end
          end
        end
        S_MACK: begin
          if (w_scl_rise) begin
            if (w_sda) begin
              w_state_nxt = S_IDLE;
            end else begin
              w_ptr_nxt   = r_ptr + 3'd1;
              w_shreg_nxt = w_rd_nxt;
              w_cnt_nxt   = 4'd8;
              w_state_nxt = S_READ;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= 4'd0;
      r_shreg   <= 8'h00;
      r_ptr     <= 3'd0;
      r_sda_oe  <= 1'b0;
      r_rw      <= 1'b0;
      r_busy    <= 1'b0;
      r_i2c_wr  <= 1'b0;
      r_wr_addr <= 3'd0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_shreg   <= w_shreg_nxt;
      r_ptr     <= w_ptr_nxt;
      r_sda_oe  <= w_oe_nxt;
      r_rw      <= w_rw_nxt;
      r_busy    <= w_busy_nxt;
      r_i2c_wr  <= w_commit;
      if (w_commit) r_wr_addr <= r_ptr;
    end
  end

  // Local write is applied last so it wins a same-cycle collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= 8'h00;
    end else begin
      if (w_commit) r_regs[r_ptr] <= w_byte;
      if (loc_we)   r_regs[loc_addr] <= loc_wdata;
    end
  end

  assign loc_rdata   = r_regs[loc_addr];
  assign sda_oe      = r_sda_oe;
  assign i2c_wr      = r_i2c_wr;
  assign i2c_wr_addr = r_wr_addr;
  assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_target_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_target_regs
// Brief    : Self-checking bench for i2c_target_regs (bit-banged I2C master,
//            local-port vector table, write/read scoreboards).
// Revision : 1.0
// ============================================================================
module tb_i2c_target_regs;
  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_i, sda_i;
  logic       sda_oe;
  logic       loc_we = 1'b0;
  logic [2:0] loc_addr = 3'd0;
  logic [7:0] loc_wdata = 8'h00;
  logic [7:0] loc_rdata;
  logic       i2c_wr;
  logic [2:0] i2c_wr_addr;
  logic       busy;

  int         total = 0;
  int         bad = 0;
  logic [7:0] mdl [8];
  logic [2:0] wr_q [$];
  logic [7:0] rd_q [$];
  logic [2:0] exp_addr;
  logic       prev_wr = 1'b0;
  logic       mon_oe = 1'b0;
  logic       oe_seen = 1'b0;

  typedef struct packed {
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl [8];

  // Open-drain bus: master and target both only pull low.
  assign scl_i = scl_m;
  assign sda_i = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_target_regs #(.DEV_ADDR(7'h63)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .loc_rdata(loc_rdata), .i2c_wr(i2c_wr), .i2c_wr_addr(i2c_wr_addr),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (i2c_wr) begin
      if (wr_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wr_unexpected: got pulse addr %0d want none", i2c_wr_addr);
      end else begin
        exp_addr = wr_q.pop_front();
        chk("wr_addr", 32'(i2c_wr_addr), 32'(exp_addr));
      end
      chk("wr_pulse_width", 32'(prev_wr), 32'd0);
    end
    prev_wr <= i2c_wr;
    if (mon_oe && sda_oe) oe_seen <= 1'b1;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic qw();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; qw(); scl_m = 1'b1; qw(); sda_m = 1'b0; qw(); scl_m = 1'b0; qw();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qw(); scl_m = 1'b1; qw(); sda_m = 1'b1; qw();
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; qw(); scl_m = 1'b1; qw(); qw(); scl_m = 1'b0; qw();
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; qw(); scl_m = 1'b1; qw(); b = sda_i; qw(); scl_m = 1'b0; qw();
  endtask

  task automatic write_byte(input logic [7:0] dat, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(dat[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] dat);
    for (int i = 7; i >= 0; i--) read_bit(dat[i]);
    write_bit(mack);
  endtask

  // Holds a local write to the same register across the I2C commit cycle.
  task automatic write_byte_collide(input logic [7:0] dat, input logic [2:0] la,
                                    input logic [7:0] lv, output logic ack);
    logic seen;
    seen = 1'b0;
    for (int i = 7; i >= 1; i--) write_bit(dat[i]);
    sda_m = dat[0]; qw();
    loc_addr = la; loc_wdata = lv; loc_we = 1'b1; scl_m = 1'b1;
    for (int k = 0; k < 3 * Q && !seen; k++) begin
      @(negedge clk);
      if (i2c_wr) seen = 1'b1;
    end
    loc_we = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL collide_commit: got no i2c_wr pulse want one");
    end
    qw(); scl_m = 1'b0; qw();
    read_bit(ack);
  endtask

  task automatic loc_write(input logic [2:0] a, input logic [7:0] v);
    @(negedge clk);
    loc_addr = a; loc_wdata = v; loc_we = 1'b1;
    @(negedge clk);
    loc_we = 1'b0;
  endtask

  task automatic check_reg(input string name, input logic [2:0] a);
    @(negedge clk);
    loc_addr = a;
    #1 chk(name, 32'(loc_rdata), 32'(mdl[a]));
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    logic [7:0] e;

    tbl[0] = '{1'b1, 3'd1, 8'h5A, 8'h00};
    tbl[1] = '{1'b1, 3'd6, 8'hC3, 8'h00};
    tbl[2] = '{1'b0, 3'd1, 8'h00, 8'h5A};
    tbl[3] = '{1'b0, 3'd6, 8'h00, 8'hC3};
    tbl[4] = '{1'b1, 3'd1, 8'hFF, 8'h5A};
    tbl[5] = '{1'b0, 3'd1, 8'h00, 8'hFF};
    tbl[6] = '{1'b0, 3'd0, 8'h00, 8'h00};
    tbl[7] = '{1'b0, 3'd7, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;

    repeat (5) @(negedge clk);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_i2c_wr", 32'(i2c_wr), 32'd0);
    chk("rst_wr_addr", 32'(i2c_wr_addr), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Local port vectors: rdata is checked before the row's write lands.
    for (int i = 0; i < 8; i++) begin
      loc_we = tbl[i].we; loc_addr = tbl[i].addr; loc_wdata = tbl[i].wdata;
      #1 chk("tbl_rdata", 32'(loc_rdata), 32'(tbl[i].exp));
      if (tbl[i].we) mdl[tbl[i].addr] = tbl[i].wdata;
      @(negedge clk);
    end
    loc_we = 1'b0;

    // Write burst
    i2c_start();
    write_byte(8'hC6, ack); chk("wb_addr_ack", 32'(ack), 32'd0);
    chk("wb_busy_on", 32'(busy), 32'd1);
    write_byte(8'h02, ack); chk("wb_ptr_ack", 32'(ack), 32'd0);
    wr_q.push_back(3'd2); mdl[2] = 8'hA5;
    write_byte(8'hA5, ack); chk("wb_d0_ack", 32'(ack), 32'd0);
    wr_q.push_back(3'd3); mdl[3] = 8'h5A;
    write_byte(8'h5A, ack); chk("wb_d1_ack", 32'(ack), 32'd0);
    i2c_stop();
    repeat (6) @(negedge clk);
    chk("wb_busy_off", 32'(busy), 32'd0);
    chk("wb_wrq_empty", 32'(wr_q.size()), 32'd0);
    check_reg("wb_reg2", 3'd2);
    check_reg("wb_reg3", 3'd3);

    // Pointer wrap, then a same-cycle local/I2C collision on reg[1]
    i2c_start();
    write_byte(8'hC6, ack);
    write_byte(8'h07, ack);
    wr_q.push_back(3'd7); mdl[7] = 8'h11;
    write_byte(8'h11, ack); chk("wrap_d0_ack", 32'(ack), 32'd0);
    wr_q.push_back(3'd0); mdl[0] = 8'h22;
    write_byte(8'h22, ack);
    wr_q.push_back(3'd1); mdl[1] = 8'h77;
    write_byte_collide(8'h33, 3'd1, 8'h77, ack);
    i2c_stop();
    check_reg("wrap_reg7", 3'd7);
    check_reg("wrap_reg0", 3'd0);
    check_reg("collide_reg1", 3'd1);

    // Read with repeated START
    loc_write(3'd4, 8'h3C); mdl[4] = 8'h3C;
    loc_write(3'd5, 8'hC3); mdl[5] = 8'hC3;
    i2c_start();
    write_byte(8'hC6, ack);
    write_byte(8'h04, ack);
    i2c_start();
    write_byte(8'hC7, ack); chk("rd_addr_ack", 32'(ack), 32'd0);
    rd_q.push_back(8'h3C); rd_q.push_back(8'hC3);
    read_byte(1'b0, d); e = rd_q.pop_front(); chk("rd_byte0", 32'(d), 32'(e));
    read_byte(1'b1, d); e = rd_q.pop_front(); chk("rd_byte1", 32'(d), 32'(e));
    chk("rd_released", 32'(sda_oe), 32'd0);
    i2c_stop();
    repeat (6) @(negedge clk);
    chk("rd_busy_off", 32'(busy), 32'd0);

    // Address mismatch
    oe_seen = 1'b0; mon_oe = 1'b1;
    i2c_start();
    write_byte(8'h90, ack); chk("mm_nack", 32'(ack), 32'd1);
    chk("mm_busy", 32'(busy), 32'd0);
    write_byte(8'h00, ack);
    write_byte(8'hFF, ack);
    i2c_stop();
    repeat (6) @(negedge clk);
    mon_oe = 1'b0;
    chk("mm_oe_never", 32'(oe_seen), 32'd0);
    for (int i = 0; i < 8; i++) check_reg("mm_regs", 3'(i));

    // STOP after 4 data bits: no commit
    i2c_start();
    write_byte(8'hC6, ack);
    write_byte(8'h05, ack);
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    i2c_stop();
    repeat (6) @(negedge clk);
    chk("partial_busy", 32'(busy), 32'd0);
    check_reg("partial_reg5", 3'd5);

    // 1-clk SCL pulse in the middle of a data byte
    i2c_start();
    write_byte(8'hC6, ack); chk("gl_addr_ack", 32'(ack), 32'd0);
    write_byte(8'h06, ack); chk("gl_ptr_ack", 32'(ack), 32'd0);
    wr_q.push_back(3'd6);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    mdl[6] = 8'h0F;
`else
    mdl[6] = 8'h07;
`endif
    for (int i = 0; i < 4; i++) write_bit(1'b0);
    sda_m = 1'b0; qw();
    scl_m = 1'b1; @(negedge clk); scl_m = 1'b0; qw();
    for (int i = 0; i < 4; i++) write_bit(1'b1);
    read_bit(ack);
    i2c_stop();
    repeat (6) @(negedge clk);
    check_reg("glitch_reg6", 3'd6);
    chk("gl_wrq_empty", 32'(wr_q.size()), 32'd0);

    // Reset asserted while the target drives a read bit low
    i2c_start();
    write_byte(8'hC6, ack);
    write_byte(8'h04, ack);
    i2c_start();
    write_byte(8'hC7, ack);
    read_bit(ack);
    sda_m = 1'b1; qw(); scl_m = 1'b1; qw();
    chk("mid_read_oe", 32'(sda_oe), 32'd1);
    rst = 1'b0;
    #1 chk("rst_mid_oe", 32'(sda_oe), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
    for (int i = 0; i < 8; i++) check_reg("rst_regs", 3'(i));

    // Pointer restarts at 0; read without a PTR phase
    loc_write(3'd0, 8'h81); mdl[0] = 8'h81;
    i2c_start();
    write_byte(8'hC7, ack); chk("post_addr_ack", 32'(ack), 32'd0);
    rd_q.push_back(8'h81);
    read_byte(1'b1, d); e = rd_q.pop_front(); chk("post_rd_byte", 32'(d), 32'(e));
    i2c_stop();
    repeat (6) @(negedge clk);
    chk("end_wrq_empty", 32'(wr_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
